// File: rtl/cam_pixel_capture_pkg.sv
// Shared definitions for the OV7670 pixel capture path: default VGA geometry,
// RGB565 field layout, capture FSM encodings and the width helper.
package cam_pixel_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [1:0] ST_WAIT_SETUP = 2'd0;
  localparam logic [1:0] ST_WAIT_VS_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_VS_LO = 2'd2;
  localparam logic [1:0] ST_ACTIVE     = 2'd3;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera pin, plus a delay flop
// giving single-cycle rising/falling edge strobes in the clk_i domain.
module cam_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Oversampled OV7670 parallel-port capture: pairs bytes into RGB565 pixels and
// emits a position-tagged stream with frame/line markers and sticky error flags.
module cam_pixel_capture
  import cam_pixel_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        setup_done_i,
  input  logic        pclk_i,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic [7:0]  cam_d_i,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [15:0] pix_data_o,
  output logic [9:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic        eof_o,
  output logic [15:0] frame_cnt_o,
  output logic        overflow_o,
  output logic        geom_err_o,
  output logic [1:0]  state_o
);

  localparam int XW = clog2(H_ACTIVE + 1);
  localparam int YW = clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

  logic          pclk_lvl, pclk_rise, pclk_fall;
  logic          vsync_s, vsync_rise, vsync_fall;
  logic          href_s, href_rise, href_fall;
  logic          unused_edges;
  logic [7:0]    d_meta_q, d_sync_q;
  logic [7:0]    hi_q;
  logic          phase_q;
  logic          line_seen_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [1:0]    state_q;
  rgb565_t       pix_q;

  cam_sync_edge u_sync_pclk (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(pclk_i),
    .sync_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );
  cam_sync_edge u_sync_vsync (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(vsync_i),
    .sync_o(vsync_s), .rise_o(vsync_rise), .fall_o(vsync_fall)
  );
  cam_sync_edge u_sync_href (
    .clk_i(clk_i), .rst_i(rst_i), .async_i(href_i),
    .sync_o(href_s), .rise_o(href_rise), .fall_o(href_fall)
  );

  assign unused_edges = ^{pclk_lvl, pclk_fall, vsync_fall, href_rise};

  // Data shares the same two-stage depth as href/pclk so byte and strobe align.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      d_meta_q <= '0;
      d_sync_q <= '0;
    end else begin
      d_meta_q <= cam_d_i;
      d_sync_q <= d_meta_q;
    end
  end

  // Stream handshake: a pixel transfers when pix_valid_o & pix_ready_i on a clk_i
  // edge. Valid is a one-cycle pulse that never waits for ready; a pulse seen
  // with ready low is lost and recorded in overflow_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_WAIT_SETUP;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      line_seen_q <= 1'b0;
      hi_q        <= '0;
      pix_q       <= '0;
      pix_valid_o <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      sof_o       <= 1'b0;
      eol_o       <= 1'b0;
      eof_o       <= 1'b0;
      frame_cnt_o <= '0;
      overflow_o  <= 1'b0;
      geom_err_o  <= 1'b0;
    end else begin
      pix_valid_o <= 1'b0;
      sof_o       <= 1'b0;
      eol_o       <= 1'b0;
      eof_o       <= 1'b0;
      if (pix_valid_o && !pix_ready_i) overflow_o <= 1'b1;

      if (!setup_done_i) begin
        state_q     <= ST_WAIT_SETUP;
        x_q         <= '0;
        y_q         <= '0;
        phase_q     <= 1'b0;
        line_seen_q <= 1'b0;
        pix_q       <= '0;
        pix_x_o     <= '0;
        pix_y_o     <= '0;
      end else begin
        case (state_q)
          ST_WAIT_SETUP: state_q <= ST_WAIT_VS_HI;
          ST_WAIT_VS_HI: if (vsync_s) state_q <= ST_WAIT_VS_LO;
          ST_WAIT_VS_LO: begin
            if (!vsync_s) begin
              x_q         <= '0;
              y_q         <= '0;
              phase_q     <= 1'b0;
              line_seen_q <= 1'b0;
              state_q     <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (vsync_rise) begin
              state_q <= ST_WAIT_VS_LO;
              if (y_q == Y_END) begin
                eof_o       <= 1'b1;
                frame_cnt_o <= frame_cnt_o + 16'd1;
              end else begin
                geom_err_o <= 1'b1;
              end
            end else if (href_fall && !vsync_s) begin
              if (phase_q || (x_q != X_END)) geom_err_o <= 1'b1;
              x_q         <= '0;
              phase_q     <= 1'b0;
              line_seen_q <= 1'b0;
              if (line_seen_q && (y_q != Y_END)) y_q <= y_q + 1'b1;
            end else if (pclk_rise && href_s && !vsync_s) begin
              if (!phase_q) begin
                hi_q    <= d_sync_q;
                phase_q <= 1'b1;
              end else begin
                phase_q     <= 1'b0;
                line_seen_q <= 1'b1;
                // Position saturates at the active size so a runaway line cannot wrap.
                if (x_q != X_END) x_q <= x_q + 1'b1;
                if ((x_q != X_END) && (y_q != Y_END)) begin
                  pix_valid_o <= 1'b1;
                  pix_q       <= rgb565_t'({hi_q, d_sync_q});
                  pix_x_o     <= 10'(x_q);
                  pix_y_o     <= 9'(y_q);
                  sof_o       <= (x_q == '0) && (y_q == '0);
                  eol_o       <= (x_q == X_LAST);
                end else begin
                  geom_err_o <= 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_WAIT_SETUP;
        endcase
      end
    end
  end

  assign pix_data_o = pix_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture on a reduced 8x6 geometry: camera BFM
// pushes expected pixels into a queue, a negedge monitor pops and compares.
module tb_cam_pixel_capture;
  import cam_pixel_capture_pkg::*;

  localparam int H = 8;
  localparam int V = 6;
  localparam int PW = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setup_done;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  cam_d;
  logic        pix_ready = 1'b1;
  logic        pix_valid_o;
  logic [15:0] pix_data_o;
  logic [9:0]  pix_x_o;
  logic [8:0]  pix_y_o;
  logic        sof_o, eol_o, eof_o;
  logic [15:0] frame_cnt_o;
  logic        overflow_o, geom_err_o;
  logic [1:0]  state_o;

  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int eof_cnt = 0;
  int drop_x = -1;
  int drop_y = -1;

  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_i(clk), .rst_i(rst_n), .setup_done_i(setup_done),
    .pclk_i(pclk), .vsync_i(vsync), .href_i(href), .cam_d_i(cam_d),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready),
    .pix_data_o(pix_data_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
    .frame_cnt_o(frame_cnt_o), .overflow_o(overflow_o),
    .geom_err_o(geom_err_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", name, got, exp);
  endtask

  // camera BFM: data and href change while pclk is low, sampled on its rise
  task automatic pclk_cycle();
    #20 pclk = 1'b1;
    #20 pclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_d = b;
    href  = 1'b1;
    pclk_cycle();
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    repeat (n) pclk_cycle();
  endtask

  task automatic run_frame(input int nlines, input int short_line, input bit cap,
                           input int on_line, input int off_line);
    bit c;
    c = cap;
    vsync = 1'b0;
    idle(4);
    for (int l = 0; l < nlines; l++) begin
      if (l == on_line) setup_done = 1'b1;
      for (int p = 0; p < H; p++) begin
        send_byte(8'(p));
        if (l == short_line && p == H - 1) break;
        if (l == off_line && p == 3) begin
          setup_done = 1'b0;
          c = 1'b0;
        end
        if (c && l < V)
          exp_q.push_back({8'(p), 8'(l), 10'(p), 9'(l), 1'(p == 0 && l == 0), 1'(p == H - 1)});
        send_byte(8'(l));
      end
      idle(4);
    end
    vsync = 1'b1;
    idle(6);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    pix_ready = !(pix_valid_o && (int'(pix_x_o) == drop_x) && (int'(pix_y_o) == drop_y));
    if (rst_n) begin
      if (eof_o) eof_cnt++;
      if (pix_valid_o) begin
        if (sof_o) sof_cnt++;
        if (eol_o) eol_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pixel got x=%0d y=%0d data=%h expected none",
                   pix_x_o, pix_y_o, pix_data_o);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          n_checks++;
          if ({pix_data_o, pix_x_o, pix_y_o, sof_o, eol_o} === e) n_pass++;
          else $display("FAIL pixel got data=%h x=%0d y=%0d sof=%b eol=%b expected data=%h x=%0d y=%0d sof=%b eol=%b",
                        pix_data_o, pix_x_o, pix_y_o, sof_o, eol_o,
                        e[36:21], e[20:11], e[10:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    setup_done = 1'b0;
    pclk = 1'b0; vsync = 1'b0; href = 1'b0; cam_d = '0;
    repeat (8) begin
      @(negedge clk);
      pclk       = 1'($urandom_range(0, 1));
      vsync      = 1'($urandom_range(0, 1));
      href       = 1'($urandom_range(0, 1));
      cam_d      = 8'($urandom_range(0, 255));
      setup_done = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_flags", {pix_valid_o, sof_o, eol_o, eof_o, overflow_o, geom_err_o}, '0);
    check("rst_data", pix_data_o, '0);
    check("rst_xy", {pix_x_o, pix_y_o}, '0);
    check("rst_frame_cnt", frame_cnt_o, '0);
    check("rst_state", state_o, ST_WAIT_SETUP);

    pclk = 1'b0; vsync = 1'b1; href = 1'b0; cam_d = '0; setup_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #3;

    // setup held low: nothing captured for two frames
    run_frame(V, -1, 1'b0, -1, -1);
    run_frame(V, -1, 1'b0, -1, -1);
    check("nosetup_state", state_o, ST_WAIT_SETUP);
    check("nosetup_frames", frame_cnt_o, 16'd0);

    // nominal: setup rises mid frame 1, frames 2 and 3 captured
    run_frame(V, -1, 1'b0, 2, -1);
    check("align_state", state_o, ST_WAIT_VS_LO);
    run_frame(V, -1, 1'b1, -1, -1);
    run_frame(V, -1, 1'b1, -1, -1);
    check("nom_frame_cnt", frame_cnt_o, 16'd2);
    check("nom_eof_cnt", eof_cnt, 2);
    check("nom_sof_cnt", sof_cnt, 2);
    check("nom_eol_cnt", eol_cnt, 2 * V);
    check("nom_overflow", overflow_o, 1'b0);
    check("nom_geom_err", geom_err_o, 1'b0);

    // back-pressure on pixel (5,3)
    drop_x = 5; drop_y = 3;
    run_frame(V, -1, 1'b1, -1, -1);
    drop_x = -1; drop_y = -1;
    check("bp_overflow", overflow_o, 1'b1);
    check("bp_frame_cnt", frame_cnt_o, 16'd3);
    check("bp_geom_err", geom_err_o, 1'b0);

    // geometry: odd-length line 2, then a frame one line short
    run_frame(V, 2, 1'b1, -1, -1);
    check("odd_geom_err", geom_err_o, 1'b1);
    check("odd_frame_cnt", frame_cnt_o, 16'd4);
    check("odd_eol_cnt", eol_cnt, 3 * V + V - 1);
    run_frame(V - 1, -1, 1'b1, -1, -1);
    check("short_frame_cnt", frame_cnt_o, 16'd4);
    check("short_eof_cnt", eof_cnt, 4);

    // abort mid line 3, then realign on a full vsync cycle
    run_frame(V, -1, 1'b1, -1, 3);
    check("abort_state", state_o, ST_WAIT_SETUP);
    check("abort_frame_cnt", frame_cnt_o, 16'd4);
    check("abort_eof_cnt", eof_cnt, 4);
    run_frame(V, -1, 1'b0, 2, -1);
    check("resume_wait", frame_cnt_o, 16'd4);
    run_frame(V, -1, 1'b1, -1, -1);
    check("resume_frame_cnt", frame_cnt_o, 16'd5);
    check("resume_eof_cnt", eof_cnt, 5);

    // frame counter wrap
    force dut.frame_cnt_o = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_o;
    #3;
    run_frame(V, -1, 1'b1, -1, -1);
    check("wrap_frame_cnt", frame_cnt_o, 16'd0);
    check("wrap_eof_cnt", eof_cnt, 6);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
